// File: rtl/stack_ctrl.sv
// LIFO stack controller: one request at a time, sequenced through a small FSM.
// Storage is a register array addressed by the stack pointer (sp == count).
module stack_ctrl #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic [PW:0]      count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_WR = 3'd1,
        POP_RD  = 3'd2,
        TOS_RD  = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [PW:0] ONE      = (PW+1)'(1);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [PW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW:0]      sp_m1;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;

    assign sp_m1   = sp_q - ONE;
    assign top_idx = sp_m1[PW-1:0];
    assign wr_idx  = sp_q[PW-1:0];

    assign full      = (sp_q == FULL_CNT);
    assign empty     = (sp_q == '0);
    assign count     = sp_q;
    assign dout      = dout_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE) || (state_q == ERR);
    assign err       = (state_q == ERR);

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        dout_d  = dout_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        case (state_q)
            IDLE: begin
                // Priority push > pop > tos; the losers are simply dropped.
                if (push) begin
                    hold_d = din;
                    if (full) begin
                        state_d = ERR;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = PUSH_WR;
                    end
                end else if (pop || tos) begin
                    if (empty) begin
                        state_d = ERR;
                        udf_d   = 1'b1;
                    end else begin
                        state_d = pop ? POP_RD : TOS_RD;
                    end
                end
            end
            PUSH_WR: begin
                sp_d    = sp_q + ONE;
                state_d = DONE;
            end
            POP_RD: begin
                dout_d  = mem_q[top_idx];
                sp_d    = sp_m1;
                state_d = DONE;
            end
            TOS_RD: begin
                dout_d  = mem_q[top_idx];
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sp_q    <= '0;
            dout_q  <= '0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset; a write abandoned by reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && state_q == PUSH_WR) begin
            mem_q[wr_idx] <= hold_q;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios followed by random
// requests, compared against a queue-based LIFO model.
module tb_stack_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int PW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop  = 1'b0;
    logic             tos  = 1'b0;
    logic [WIDTH-1:0] din  = '0;
    logic [WIDTH-1:0] dout;
    logic             ready, done, err, full, empty, overflow, underflow;
    logic [PW:0]      count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_ovf  = 1'b0;
    logic             m_udf  = 1'b0;

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
        .dout(dout), .ready(ready), .done(done), .err(err), .full(full),
        .empty(empty), .overflow(overflow), .underflow(underflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"},     32'(count),     32'(mq.size()));
        chk({tag, "_empty"},     32'(empty),     32'(mq.size() == 0));
        chk({tag, "_full"},      32'(full),      32'(mq.size() == DEPTH));
        chk({tag, "_dout"},      32'(dout),      32'(m_dout));
        chk({tag, "_overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, "_underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Called at a negedge; leaves the bench at a negedge with the stack idle.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        push = 1'b0; pop = 1'b0; tos = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk({tag, "_ready"}, 32'(ready), 1);
        chk({tag, "_done"},  32'(done),  0);
        chk({tag, "_err"},   32'(err),   0);
        chk_state(tag);
    endtask

    // Issue one request from IDLE at a negedge; checks the full done/err timeline.
    task automatic do_req(input string tag, input logic p, input logic po,
                          input logic t, input logic [WIDTH-1:0] d);
        logic err_exp;
        chk({tag, "_ready_pre"}, 32'(ready), 1);
        push = p; pop = po; tos = t; din = d;
        err_exp = 1'b0;
        if (p) begin
            if (mq.size() == DEPTH) begin err_exp = 1'b1; m_ovf = 1'b1; end
            else mq.push_back(d);
        end else if (po) begin
            if (mq.size() == 0) begin err_exp = 1'b1; m_udf = 1'b1; end
            else m_dout = mq.pop_back();
        end else if (t) begin
            if (mq.size() == 0) begin err_exp = 1'b1; m_udf = 1'b1; end
            else m_dout = mq[$];
        end
        @(negedge clk);
        // Requests while busy must be ignored.
        push = 1'($urandom); pop = 1'($urandom); tos = 1'($urandom); din = WIDTH'($urandom);
        chk({tag, "_ready_n1"}, 32'(ready), 0);
        chk({tag, "_done_n1"},  32'(done),  32'(err_exp));
        chk({tag, "_err_n1"},   32'(err),   32'(err_exp));
        @(negedge clk);
        if (!err_exp) begin
            push = 1'($urandom); pop = 1'($urandom); tos = 1'($urandom);
            chk({tag, "_ready_n2"}, 32'(ready), 0);
            chk({tag, "_done_n2"},  32'(done),  1);
            chk({tag, "_err_n2"},   32'(err),   0);
            @(negedge clk);
        end
        push = 1'b0; pop = 1'b0; tos = 1'b0;
        chk({tag, "_ready_end"}, 32'(ready), 1);
        chk({tag, "_done_end"},  32'(done),  0);
        chk({tag, "_err_end"},   32'(err),   0);
        chk_state(tag);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        do_reset("rst0");

        do_req("push11", 1, 0, 0, 8'h11);
        do_req("push22", 1, 0, 0, 8'h22);
        do_req("tos22",  0, 0, 1, 8'h00);
        do_req("pop22",  0, 1, 0, 8'h00);
        do_req("pop11",  0, 1, 0, 8'h00);
        do_req("pop_empty", 0, 1, 0, 8'h00);
        do_req("tos_empty", 0, 0, 1, 8'h00);

        do_reset("rst1");
        for (int i = 1; i <= DEPTH; i++) do_req("fill", 1, 0, 0, WIDTH'(i));
        do_req("push_full", 1, 0, 0, 8'h09);
        do_req("tos_full",  0, 0, 1, 8'h00);

        do_reset("rst2");
        do_req("prio", 1, 1, 1, 8'h5A);
        do_req("prio_tos", 0, 0, 1, 8'h00);
        do_req("prio_pt", 0, 1, 1, 8'h00);

        // Reset while a push is in PUSH_WR: abandoned, no done pulse.
        do_reset("rst3");
        push = 1'b1; din = 8'h33;
        @(negedge clk);
        push = 1'b0;
        chk("midrst_busy", 32'(ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_ready", 32'(ready), 1);
        chk("midrst_done",  32'(done),  0);
        chk_state("midrst");
        do_req("midrst_pop", 0, 1, 0, 8'h00);

        for (int i = 0; i < 300; i++) begin
            logic p, po, t;
            int   sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                do_reset("rnd_rst");
            end else if (sel < 10) begin
                @(negedge clk);
                chk("rnd_idle_ready", 32'(ready), 1);
                chk_state("rnd_idle");
            end else begin
                // Bias push/pop to sweep the stack between empty and full.
                p  = ($urandom_range(0, 99) < 45);
                po = ($urandom_range(0, 99) < 50);
                t  = ($urandom_range(0, 99) < 30);
                if (!p && !po && !t) t = 1'b1;
                do_req("rnd", p, po, t, WIDTH'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of stack entries; DEPTH SHALL be a power of 2, and PW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port push, input, 1 bit: request to push din.
REQ-006 The block SHALL have port pop, input, 1 bit: request to pop the top entry into dout.
REQ-007 The block SHALL have port tos, input, 1 bit: request to copy the top entry into dout without removing it.
REQ-008 The block SHALL have port din, input, WIDTH bits: push data.
REQ-009 The block SHALL have port dout, output, WIDTH bits: registered read data.
REQ-010 The block SHALL have port ready, output, 1 bit: block idle and able to accept a request.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse, coincident with done, marking a rejected request.
REQ-013 The block SHALL have port full, output, 1 bit: count == DEPTH.
REQ-014 The block SHALL have port empty, output, 1 bit: count == 0.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag for a push attempted while full.
REQ-016 The block SHALL have port underflow, output, 1 bit: sticky flag for a pop or tos attempted while empty.
REQ-017 The block SHALL have port count, output, PW+1 bits: current number of entries, 0..DEPTH.

Function
REQ-018 Storage SHALL be an internal DEPTH x WIDTH register array, indexed by stack pointer sp (PW+1 bits, sp == count).
REQ-019 The FSM SHALL have states IDLE, PUSH_WR, POP_RD, TOS_RD, DONE and ERR; ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, a request SHALL be accepted in any cycle where push, pop or tos is high; priority SHALL be push > pop > tos, and lower-priority requests in that cycle SHALL be dropped.
REQ-021 Requests raised in any state other than IDLE SHALL be ignored, with no queuing.
REQ-022 On acceptance of a push, din SHALL be latched into a holding register.
REQ-023 An accepted push with full=0 SHALL go to PUSH_WR; PUSH_WR SHALL write mem[sp] = latched din, increment sp, then go to DONE.
REQ-024 An accepted pop with empty=0 SHALL go to POP_RD; POP_RD SHALL set dout = mem[sp-1], decrement sp, then go to DONE.
REQ-025 An accepted tos with empty=0 SHALL go to TOS_RD; TOS_RD SHALL set dout = mem[sp-1], leave sp unchanged, then go to DONE.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; for a request accepted at cycle N, done SHALL be high in cycle N+2 and ready SHALL be high again in cycle N+3.
REQ-027 A push accepted while full, or a pop or tos accepted while empty, SHALL go to ERR and set overflow or underflow respectively.
REQ-028 ERR SHALL assert done=1 and err=1 for one cycle (cycle N+1), then return to IDLE.
REQ-029 ERR SHALL leave sp, storage and dout unchanged.
REQ-030 overflow and underflow SHALL remain set until reset.
REQ-031 full, empty and count SHALL be derived combinationally from sp and SHALL reflect a change in the cycle after PUSH_WR or POP_RD.
REQ-032 dout SHALL hold its value except in POP_RD and TOS_RD.
REQ-033 sp SHALL never wrap: it SHALL not exceed DEPTH and SHALL not go below 0.

Reset
REQ-034 When rst=1 at a clock edge, the block SHALL enter IDLE with sp=0, dout=0, done=0, err=0, overflow=0 and underflow=0; resulting outputs SHALL be ready=1, empty=1, full=0, count=0.
REQ-035 Reset SHALL take priority over any state or request, including mid-operation (PUSH_WR, POP_RD, TOS_RD, DONE, ERR); an in-flight operation SHALL be abandoned with no done pulse.
REQ-036 Storage contents SHALL NOT be cleared by reset and SHALL be unobservable until written.

Verification
REQ-037 Push ordering: reset, then push 0x11 at cycle N and push 0x22 when ready -> done at N+2 and at the second acceptance+2; count=2; empty=0.
REQ-038 Read-back: from state {0x11, 0x22}, tos -> dout=0x22, count=2; pop -> dout=0x22, count=1; pop -> dout=0x11, count=0, empty=1.
REQ-039 Underflow: pop on an empty stack at cycle N -> done=err=1 at N+1 only, underflow=1, count=0, dout unchanged.
REQ-040 Overflow: push 0x01..0x08, then push 0x09 -> err pulse, overflow=1, full=1; a following tos returns 0x08.
REQ-041 Priority: push=pop=tos=1 with din=0x5A in IDLE -> push only, count=1; a following tos returns 0x5A.
REQ-042 Reset mid-operation: rst=1 during PUSH_WR -> next cycle IDLE, count=0, no done pulse; a subsequent pop gives err=1 and underflow=1.
